// File: rtl/ps2_key_decoder_if.sv
// Key-event bus between the PS/2 byte receiver and the game core.
// The receiver side offers raw scan-code bytes. The decoder side returns
// collapsed key events and the held-arrow direction.
interface ps2_key_decoder_if;
    logic       key_en;
    logic [7:0] key_data;
    logic       key_valid;
    logic [7:0] keycode;
    logic       key_make;
    logic       key_ext;
    logic [2:0] move;

    modport master (
        output key_en, key_data,
        input  key_valid, keycode, key_make, key_ext, move
    );

    modport slave (
        input  key_en, key_data,
        output key_valid, keycode, key_make, key_ext, move
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code collapser.
// Folds the E0, F0, E0 F0 and E1 (Pause) prefix sequences into single key
// events. It also tracks the held arrow keys and turns them into a move code.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter bit ACCEPT_KEYPAD  = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    ps2_key_decoder_if.slave   kif
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ST_E0, ST_F0, ST_E0F0, SKIP} state_t;

    state_t        state_q, state_nxt;
    logic [2:0]    skip_q, skip_nxt;
    logic [TW-1:0] tcnt_q, tcnt_nxt;
    logic          emit, emit_make, emit_ext;

    logic          arr_hit, is_arrow;
    logic [1:0]    arr_idx;
    logic [3:0]    mask_q, mask_nxt;
    logic [2:0]    move_q, move_nxt;

    logic          valid_q, make_q, ext_q;
    logic [7:0]    code_q;

    // Fallback direction when the arrow on move is released: up > down > left > right.
    function automatic logic [2:0] prio(input logic [3:0] m);
        if (m[0])      prio = 3'd1;
        else if (m[1]) prio = 3'd2;
        else if (m[2]) prio = 3'd3;
        else if (m[3]) prio = 3'd4;
        else           prio = 3'd0;
    endfunction

    // Prefix FSM: next state, skip/timeout counters and event emission.
    always_comb begin
        state_nxt = state_q;
        skip_nxt  = skip_q;
        tcnt_nxt  = '0;
        emit      = 1'b0;
        emit_make = 1'b0;
        emit_ext  = 1'b0;
        if (kif.key_en) begin
            unique case (state_q)
                IDLE: begin
                    unique case (kif.key_data)
                        8'hE0: state_nxt = ST_E0;
                        8'hF0: state_nxt = ST_F0;
                        8'hE1: begin
                            state_nxt = SKIP;
                            skip_nxt  = 3'd7;
                        end
                        // controller responses, not keys
                        8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            emit      = 1'b1;
                            emit_make = 1'b1;
                        end
                    endcase
                end
                ST_E0: begin
                    unique case (kif.key_data)
                        8'hF0:        state_nxt = ST_E0F0;
                        8'h12, 8'h59: state_nxt = IDLE;  // fake shift
                        8'hE0:        state_nxt = ST_E0;
                        default: begin
                            emit      = 1'b1;
                            emit_make = 1'b1;
                            emit_ext  = 1'b1;
                            state_nxt = IDLE;
                        end
                    endcase
                end
                ST_F0: begin
                    emit      = 1'b1;
                    state_nxt = IDLE;
                end
                ST_E0F0: begin
                    state_nxt = IDLE;
                    if (kif.key_data != 8'h12 && kif.key_data != 8'h59) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                SKIP: begin
                    skip_nxt = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // abandon a sequence whose completing byte never arrives
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) state_nxt = IDLE;
            else                                 tcnt_nxt  = tcnt_q + TW'(1);
        end
    end

    // Decode the byte as an arrow index (0 up, 1 down, 2 left, 3 right).
    always_comb begin
        arr_hit = 1'b1;
        arr_idx = 2'd0;
        unique case (kif.key_data)
            8'h75:   arr_idx = 2'd0;
            8'h72:   arr_idx = 2'd1;
            8'h6B:   arr_idx = 2'd2;
            8'h74:   arr_idx = 2'd3;
            default: arr_hit = 1'b0;
        endcase
    end

    assign is_arrow = emit && arr_hit && (emit_ext || ACCEPT_KEYPAD);

    // Held-arrow mask and move direction for the event being emitted.
    always_comb begin
        mask_nxt = mask_q;
        move_nxt = move_q;
        if (is_arrow) begin
            if (emit_make) begin
                mask_nxt[arr_idx] = 1'b1;
                move_nxt          = {1'b0, arr_idx} + 3'd1;
            end else if (mask_q[arr_idx]) begin
                mask_nxt[arr_idx] = 1'b0;
                if (move_q == {1'b0, arr_idx} + 3'd1) move_nxt = prio(mask_nxt);
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            skip_q  <= '0;
            tcnt_q  <= '0;
            mask_q  <= '0;
            move_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            make_q  <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            skip_q  <= skip_nxt;
            tcnt_q  <= tcnt_nxt;
            mask_q  <= mask_nxt;
            move_q  <= move_nxt;
            valid_q <= emit;
            if (emit) begin
                code_q <= kif.key_data;
                make_q <= emit_make;
                ext_q  <= emit_ext;
            end
        end
    end

    assign kif.key_valid = valid_q;
    assign kif.keycode   = code_q;
    assign kif.key_make  = make_q;
    assign kif.key_ext   = ext_q;
    assign kif.move      = move_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a vector table of bytes with expected
// outputs, plus hand-written timeout and reset sequences.
module tb_ps2_key_decoder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ps2_key_decoder_if kif();

    ps2_key_decoder #(.TIMEOUT_CYCLES(16), .ACCEPT_KEYPAD(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .kif    (kif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] data;
        logic       v;
        logic [7:0] kc;
        logic       mk;
        logic       ext;
        logic [2:0] mv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic [7:0] d, input logic v,
                       input logic [7:0] kc, input logic mk, input logic ext,
                       input logic [2:0] mv);
        vec_t t;
        t.en = en; t.data = d; t.v = v; t.kc = kc; t.mk = mk; t.ext = ext; t.mv = mv;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic v, input logic [7:0] kc,
                       input logic mk, input logic ext, input logic [2:0] mv);
        logic [13:0] act, exp;
        act = {kif.key_valid, kif.keycode, kif.key_make, kif.key_ext, kif.move};
        exp = {v, kc, mk, ext, mv};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%b keycode=%h make=%b ext=%b move=%0d, expected valid=%b keycode=%h make=%b ext=%b move=%0d",
                     nm, act[13], act[12:5], act[4], act[3], act[2:0], v, kc, mk, ext, mv);
        end
    endtask

    // One clock: drive (or idle) on the falling edge, then sample just after the rising edge.
    task automatic send(input logic en, input logic [7:0] d);
        @(negedge clk);
        kif.key_en   = en;
        kif.key_data = d;
        @(posedge clk);
        #1;
        kif.key_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.key_en   = 1'b0;
        kif.key_data = 8'h00;

        // basic make / break
        add(1, 8'h1C, 1, 8'h1C, 1, 0, 0);
        add(0, 8'h00, 0, 8'h1C, 1, 0, 0);
        add(1, 8'hF0, 0, 8'h1C, 1, 0, 0);
        add(1, 8'h1C, 1, 8'h1C, 0, 0, 0);
        add(0, 8'h00, 0, 8'h1C, 0, 0, 0);
        // extended arrows: up, left, release left, release up
        add(1, 8'hE0, 0, 8'h1C, 0, 0, 0);
        add(1, 8'h75, 1, 8'h75, 1, 1, 1);
        add(1, 8'hE0, 0, 8'h75, 1, 1, 1);
        add(1, 8'h6B, 1, 8'h6B, 1, 1, 3);
        add(1, 8'hE0, 0, 8'h6B, 1, 1, 3);
        add(1, 8'hF0, 0, 8'h6B, 1, 1, 3);
        add(1, 8'h6B, 1, 8'h6B, 0, 1, 1);
        add(1, 8'hE0, 0, 8'h6B, 0, 1, 1);
        add(1, 8'hF0, 0, 8'h6B, 0, 1, 1);
        add(1, 8'h75, 1, 8'h75, 0, 1, 0);
        // Print Screen make: E0 12 E0 7C
        add(1, 8'hE0, 0, 8'h75, 0, 1, 0);
        add(1, 8'h12, 0, 8'h75, 0, 1, 0);
        add(1, 8'hE0, 0, 8'h75, 0, 1, 0);
        add(1, 8'h7C, 1, 8'h7C, 1, 1, 0);
        // Pause: E1 14 77 E1 F0 14 F0 77, all swallowed
        add(1, 8'hE1, 0, 8'h7C, 1, 1, 0);
        add(1, 8'h14, 0, 8'h7C, 1, 1, 0);
        add(1, 8'h77, 0, 8'h7C, 1, 1, 0);
        add(1, 8'hE1, 0, 8'h7C, 1, 1, 0);
        add(1, 8'hF0, 0, 8'h7C, 1, 1, 0);
        add(1, 8'h14, 0, 8'h7C, 1, 1, 0);
        add(1, 8'hF0, 0, 8'h7C, 1, 1, 0);
        add(1, 8'h77, 0, 8'h7C, 1, 1, 0);
        add(1, 8'h29, 1, 8'h29, 1, 0, 0);
        add(1, 8'hAA, 0, 8'h29, 1, 0, 0);
        // back-to-back strobes E0 74 16
        add(1, 8'hE0, 0, 8'h29, 1, 0, 0);
        add(1, 8'h74, 1, 8'h74, 1, 1, 4);
        add(1, 8'h16, 1, 8'h16, 1, 0, 4);
        // break of an arrow not held: event, move unchanged
        add(1, 8'hE0, 0, 8'h16, 1, 0, 4);
        add(1, 8'hF0, 0, 8'h16, 1, 0, 4);
        add(1, 8'h72, 1, 8'h72, 0, 1, 4);
        // keypad left, release right (not on move), release keypad left
        add(1, 8'h6B, 1, 8'h6B, 1, 0, 3);
        add(1, 8'hE0, 0, 8'h6B, 1, 0, 3);
        add(1, 8'hF0, 0, 8'h6B, 1, 0, 3);
        add(1, 8'h74, 1, 8'h74, 0, 1, 3);
        add(1, 8'hF0, 0, 8'h74, 0, 1, 3);
        add(1, 8'h6B, 1, 8'h6B, 0, 0, 0);
        // repeated E0 prefix, then fake-shift break
        add(1, 8'hE0, 0, 8'h6B, 0, 0, 0);
        add(1, 8'hE0, 0, 8'h6B, 0, 0, 0);
        add(1, 8'h1F, 1, 8'h1F, 1, 1, 0);
        add(1, 8'hE0, 0, 8'h1F, 1, 1, 0);
        add(1, 8'hF0, 0, 8'h1F, 1, 1, 0);
        add(1, 8'h12, 0, 8'h1F, 1, 1, 0);
        // down, typematic down, up, release down (not on move), release up
        add(1, 8'hE0, 0, 8'h1F, 1, 1, 0);
        add(1, 8'h72, 1, 8'h72, 1, 1, 2);
        add(1, 8'hE0, 0, 8'h72, 1, 1, 2);
        add(1, 8'h72, 1, 8'h72, 1, 1, 2);
        add(1, 8'hE0, 0, 8'h72, 1, 1, 2);
        add(1, 8'h75, 1, 8'h75, 1, 1, 1);
        add(1, 8'hE0, 0, 8'h75, 1, 1, 1);
        add(1, 8'hF0, 0, 8'h75, 1, 1, 1);
        add(1, 8'h72, 1, 8'h72, 0, 1, 1);
        add(1, 8'hE0, 0, 8'h72, 0, 1, 1);
        add(1, 8'hF0, 0, 8'h72, 0, 1, 1);
        add(1, 8'h75, 1, 8'h75, 0, 1, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        // controller response right after reset: no event
        send(1, 8'hAA);
        chk("aa_ignored", 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].en, tbl[i].data);
            chk($sformatf("vec%0d_%h", i, tbl[i].data),
                tbl[i].v, tbl[i].kc, tbl[i].mk, tbl[i].ext, tbl[i].mv);
        end

        // timeout: E0 then a long gap, so 72 arrives as a plain keypad make
        send(1, 8'hE0);
        repeat (20) send(0, 8'h00);
        chk("timeout_quiet", 0, 8'h75, 0, 1, 0);
        send(1, 8'h72);
        chk("timeout_72", 1, 8'h72, 1, 0, 2);
        send(1, 8'hF0);
        send(1, 8'h72);
        chk("keypad_down_break", 1, 8'h72, 0, 0, 0);

        // reset mid-sequence discards the pending F0
        send(1, 8'hF0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mid_seq", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        send(1, 8'h1C);
        chk("after_reset_1c", 1, 8'h1C, 1, 0, 0);

        // arrow held, asynchronous reset clears move without a clock edge
        send(1, 8'hE0);
        send(1, 8'h74);
        chk("right_held", 1, 8'h74, 1, 1, 4);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_move", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        send(0, 8'h00);
        chk("post_reset_idle", 0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits between the PS/2 receive controller and the game core (`system`).
- Consumes raw PS/2 set-2 scan-code bytes (one-cycle `key_en` strobe with `key_data`) and collapses prefix sequences (E0, F0, E0 F0, E1 Pause) into single key events.
- Each key event carries `keycode`, a make/break flag and an extended flag.
- Also tracks held arrow keys and drives a 3-bit `move` direction code; the game core uses `move` for motion and the board shows it on a hex digit.

Parameters:
- TIMEOUT_CYCLES, 2500000: clocks allowed between prefix byte and completing byte before the sequence is abandoned (50 ms at 50 MHz).
- ACCEPT_KEYPAD, 1: when 1, the non-extended codes 75/72/6B/74 (keypad 8/2/4/6) also count as arrows.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- key_en  in  1  one-cycle strobe: `key_data` valid
- key_data  in  8  received scan-code byte
- key_valid  out  1  one-cycle pulse: new event on `keycode`/`key_make`/`key_ext`
- keycode  out  8  final scan code of the last event (prefixes stripped)
- key_make  out  1  1 = press/typematic repeat, 0 = release
- key_ext  out  1  1 = event was E0-prefixed
- move  out  3  0 none, 1 up, 2 down, 3 left, 4 right; 5-7 never driven

Behaviour:
- Interface as decided: one clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset: all outputs 0, held-arrow mask 0, FSM IDLE, timeout counter 0, skip counter 0. Applies immediately at any point, including mid-sequence; a partial sequence is discarded.
- FSM states: IDLE, E0, F0, E0F0, SKIP. A byte is consumed only on cycles where `key_en`=1.
- IDLE transitions:
  - E0 -> E0.
  - F0 -> F0.
  - E1 -> SKIP with skip count 7.
  - Controller responses AA, FA, EE, FC, FE, 00, FF are ignored; stay IDLE, no event.
  - Any other byte: emit make, ext=0; stay IDLE.
- E0 transitions:
  - F0 -> E0F0.
  - 12 or 59 (fake shift) -> IDLE, no event.
  - E0 -> stays E0.
  - Else: emit make, ext=1; -> IDLE.
- F0 transitions: any byte emits break, ext=0; -> IDLE.
- E0F0 transitions:
  - 12 or 59 -> IDLE, no event.
  - Else: emit break, ext=1; -> IDLE.
- SKIP: each byte decrements the count; at count 1 -> IDLE. No events are emitted from SKIP.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle without `key_en` and clears on every byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no event.
  - The counter is held at 0 in IDLE.
- Emit timing:
  - The byte is sampled at edge N (`key_en`=1).
  - From edge N onward, `key_valid`=1 for exactly one cycle, and `keycode`/`key_make`/`key_ext` update at the same edge.
  - Data outputs hold until the next event.
  - Back-to-back `key_en` strobes each get full processing; there is no throughput limit.
- Arrow codes: 75 up, 72 down, 6B left, 74 right.
  - An event is an arrow if it is extended, or if it is non-extended and ACCEPT_KEYPAD=1.
- Held mask, 4 bits: an arrow make sets its bit; an arrow break clears it. Non-arrow events do not touch the mask.
- `move` is registered and updates on the same edge as `key_valid`:
  - Arrow make (including typematic repeat): `move` = that arrow.
  - Arrow break of the arrow currently on `move`: fall back to the highest-priority remaining held arrow (up > down > left > right), or 0 if none.
  - Arrow break of any other arrow: `move` unchanged.
  - Break for an arrow not in the mask: mask and `move` unchanged; the event is still emitted.

Test Plan:
- Reset, then byte 1C (A) -> next cycle `key_valid`=1, `keycode`=1C, `key_make`=1, `key_ext`=0, `move`=0. Then F0,1C -> one pulse only, `keycode`=1C, `key_make`=0.
- E0,75 -> `move`=1, `key_ext`=1. Then E0,6B -> `move`=3. Then E0,F0,6B -> `move`=1. Then E0,F0,75 -> `move`=0; exactly 4 pulses total.
- Print Screen make E0,12,E0,7C -> exactly one event: `keycode`=7C, `key_ext`=1. Pause E1,14,77,E1,F0,14,F0,77 -> zero pulses; next byte 29 -> make 29.
- TIMEOUT_CYCLES=16: send E0, wait 20 cycles, send 72 -> event with `key_ext`=0, `keycode`=72; `move`=2 only if ACCEPT_KEYPAD=1, else 0.
- Byte AA after reset -> no pulse. Send F0, assert `resetn`=0 for 2 cycles, release, send 1C -> make event `keycode`=1C. Also: arrow held, then reset -> `move`=0 immediately.
- Strobes on 3 consecutive cycles E0,74,16 -> events on the following two cycles: right make (`move`=4), then 16 make, `key_ext`=0.
